// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV32I core: fetch FSM state type and
// the fetch-stage constants.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle around the fetch stage: instruction memory request/response,
// decode handshake and the execute redirect.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Fetch stage side.
    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

    // Environment side: memory, decode and execute.
    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

    // Passive observer for protocol checking.
    modport mon (
        input imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
              imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
              redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit_adder.sv
// Plain modulo-2^W adder shared by the core datapath.
module adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/fetch_unit_chk.sv
// Instruction memory protocol checker: a response must belong to an accepted
// request. A response arriving right after reset, before the first new
// request is accepted, is an orphan of the request killed by reset and is
// tolerated because the fetch unit ignores it.
module fetch_unit_chk (
    input logic      clk,
    input logic      rst_n,
    fetch_unit_if.mon bus
);

    logic r_outstanding;
    logic r_post_reset;

    // Track whether an accepted request still awaits its response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= 1'b0;
            r_post_reset  <= 1'b1;
        end else begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                r_outstanding <= 1'b1;
                r_post_reset  <= 1'b0;
            end else if (bus.imem_rsp_valid) begin
                r_outstanding <= 1'b0;
            end
        end
    end

    a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_rsp_valid |-> (r_outstanding || r_post_reset))
        else $error("imem response without an outstanding request");

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word request at a time,
// captures the returned word and presents it to decode; execute may resteer.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic         r_drop;
    logic         w_drop_nxt;
    logic [31:0]  r_instr;
    logic [31:0]  w_instr_nxt;
    logic [31:0]  r_instr_pc;
    logic [31:0]  w_instr_pc_nxt;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_redirect_pc;
    logic         w_handshake;

    adder #(.W(32)) u_pc_adder (
        .i_a   (r_pc),
        .i_b   (PC_STEP),
        .o_sum (w_pc_plus4)
    );

    assign w_redirect_pc = bus.redirect_pc & ~32'd3;
    assign w_handshake   = (r_state == REQ) && bus.imem_req_ready;

    // Next-state and datapath update rules for the fetch FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_drop_nxt     = r_drop;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
            end
            REQ: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                end else begin
                    w_pc_nxt = r_pc;
                end
                if (w_handshake) begin
                    // A redirect racing the accept kills the accepted fetch.
                    w_state_nxt = WAIT;
                    w_drop_nxt  = bus.redirect_valid;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (bus.redirect_valid) begin
                        w_pc_nxt    = w_redirect_pc;
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = REQ;
                    end else if (r_drop) begin
                        // pc already holds the redirect target.
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = REQ;
                    end else begin
                        w_instr_nxt    = bus.imem_rsp_data;
                        w_instr_pc_nxt = r_pc;
                        w_pc_nxt       = w_pc_plus4;
                        w_state_nxt    = HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    w_pc_nxt   = w_redirect_pc;
                    w_drop_nxt = 1'b1;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = REQ;
                end else if (bus.instr_ready) begin
                    w_state_nxt = REQ;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, PC and instruction register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_drop     <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_instr_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_drop     <= w_drop_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
        end
    end

    assign bus.imem_req_valid = (r_state == REQ);
    assign bus.imem_req_addr  = r_pc;
    assign bus.instr_valid    = (r_state == HOLD);
    assign bus.instr          = r_instr;
    assign bus.instr_pc       = r_instr_pc;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the multi-cycle RV32I core. It owns the PC and issues one word request at a time to instruction memory. It captures the returned word into an instruction register and presents it, with its PC, to decode (immediate generator, control) over a valid/ready handshake. Execute drives a redirect to resteer the PC on taken branches, jal and jalr.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
NOP_INSTR, 32'h0000_0013, value of instr after reset (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  32  word-aligned fetch address
imem_req_ready  in  1  memory accepts request this cycle
imem_rsp_valid  in  1  read data valid; at most one per accepted request, earliest the cycle after acceptance
imem_rsp_data  in  32  instruction word
instr_valid  out  1  instr/instr_pc valid to decode
instr  out  32  fetched instruction
instr_pc  out  32  address of instr
instr_ready  in  1  decode consumes instr this cycle
redirect_valid  in  1  resteer request from execute
redirect_pc  in  32  new PC; bits [1:0] forced to 0 internally

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=RESET_PC, drop=0, instr=NOP_INSTR, instr_pc=RESET_PC. All outputs registered or decoded from state: imem_req_valid=0, instr_valid=0, imem_req_addr=RESET_PC.
- States: IDLE, REQ, WAIT, HOLD. imem_req_valid=(state==REQ). instr_valid=(state==HOLD). imem_req_addr=pc.
- IDLE: always goes to REQ on the next edge. The first request is visible 1 cycle after rst_n deasserts.
- REQ, handshake (valid&&ready): go WAIT.
- REQ, redirect_valid: pc<=redirect_pc.
- REQ, redirect and handshake in the same cycle: drop<=1, go WAIT. The accepted address is the old pc; its response is discarded.
- REQ, redirect without handshake: stay REQ. The address changes while valid is held; the instruction memory wrapper tolerates this.
- WAIT, rsp_valid with no redirect and drop=0: instr<=rsp_data, instr_pc<=pc, pc<=pc+4, go HOLD.
- WAIT, rsp_valid with drop=1: discard the data, drop<=0, go REQ. pc is unchanged and already holds the redirect target.
- WAIT, redirect with no rsp_valid: pc<=redirect_pc, drop<=1, stay WAIT. Later redirects overwrite pc; drop stays 1.
- WAIT, redirect and rsp_valid in the same cycle: discard the data, pc<=redirect_pc, drop<=0, go REQ.
- HOLD, instr_ready with no redirect: go REQ. Minimum loop is REQ->WAIT->HOLD, 3 cycles per instruction with zero-wait memory.
- HOLD, redirect (regardless of instr_ready): pc<=redirect_pc, go REQ. instr_valid deasserts the next cycle. The held instr is treated as consumed or squashed by the upstream pipeline.
- instr and instr_pc hold their value outside HOLD; they change only on a capture.
- rsp_valid outside WAIT is a protocol error. It is ignored, with an assertion in simulation.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000, no flag.
- Reset mid-operation: immediately returns to the reset values. Any outstanding memory response after release is ignored, because state is IDLE/REQ, not WAIT.

Decomposition:
- Shared package core_pkg: fetch_state_t enum {IDLE,REQ,WAIT,HOLD}, the constants NOP_INSTR, RESET_PC_DEFAULT and PC_STEP=32'd4.
- pc+4 uses the existing adder module. No other sub-module; FSM and registers stay in fetch_unit.

Test Plan:
- Reset release, memory ready=1, rsp 1 cycle later with data 32'h00500093, decode ready=1 -> req addr 0 at cycle 1; instr_valid at cycle 3 with instr=32'h00500093, instr_pc=0; next req addr 4.
- Memory ready held 0 for 3 cycles -> req_valid and addr 0 stay asserted and stable; no WAIT entry until ready=1.
- Decode stalls (instr_ready=0) 4 cycles -> instr_valid=1 and instr/instr_pc unchanged; no new request issued; request for pc+4 one cycle after ready.
- Redirect to 32'h0000_0100 while in WAIT for addr 8, rsp later returns 32'hDEADBEEF -> data discarded, instr_valid stays 0, next req addr 32'h100, instr_pc=32'h100 on the following capture.
- Redirect to 32'h40 coincident with rsp_valid; separately, redirect in HOLD with instr_ready=1 -> both: no capture of the old word, next req addr 32'h40, instr_valid=0 the next cycle.
- PC at 32'hFFFF_FFFC fetched -> next request addr 32'h0000_0000. Assert rst_n low during WAIT -> outputs immediately at reset values; post-release rsp_valid ignored.
